ram_burst_master: RTL and testbench

- Initiator for the single-port user RAM word interface (wr_en / rd_en / addr / write data / read data).
- Executes command-driven bursts:
  - Write bursts take 32-bit words from a valid/ready input stream and store them at consecutive addresses.
  - Read bursts fetch consecutive words and present them on a valid/ready output stream.
- Sits between a streaming producer/consumer (e.g. BRLWE polynomial loader) and user RAM.

---
 rtl/ram_burst_master.sv | 177 +++++++++++++++++
 tb/tb_ram_burst_master.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_master.sv
// ram_burst_master: command-driven burst initiator for a single-port word RAM.
// Write bursts move words from a valid/ready input stream into consecutive
// RAM addresses; read bursts fetch consecutive words onto a valid/ready
// output stream. Addresses wrap modulo 2^ADDR_BIT.
// Optional build macro: RAM_BURST_CHECKSUM_EN (running XOR of burst words).
module ram_burst_master #(
  parameter int unsigned ADDR_BIT = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_start_i,
  input  logic                cmd_wr_i,
  input  logic [ADDR_BIT-1:0] cmd_addr_i,
  input  logic [ADDR_BIT:0]   cmd_len_i,
  output logic                busy_o,
  output logic                done_o,
  input  logic [31:0]         s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic [31:0]         m_data_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic                ram_wr_en_o,
  output logic                ram_rd_en_o,
  output logic [ADDR_BIT-1:0] ram_addr_o,
  output logic [31:0]         ram_wdata_o,
  input  logic [31:0]         ram_rdata_i,
  output logic [31:0]         checksum_o
);

  localparam int unsigned LEN_W  = ADDR_BIT + 1;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD_ADDR,
    S_RD_CAP,
    S_RD_OUT,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_BIT-1:0] ptr;
  logic [LEN_W-1:0]    cnt;
  logic                accept;
  logic                wr_fire;
  logic                rd_fire;
  logic                last;

  // A command is taken whenever the block is not busy (IDLE or the DONE cycle)
  assign accept  = cmd_start_i && ((state == S_IDLE) || (state == S_DONE));
  assign wr_fire = (state == S_WR) && s_valid_i;
  assign rd_fire = (state == S_RD_OUT) && m_ready_i;
  assign last    = (cnt == LEN_W'(1));

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt   = state;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    s_ready_o   = 1'b0;
    ram_wr_en_o = 1'b0;
    ram_rd_en_o = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;

    case (state)
      S_IDLE, S_DONE: begin
        done_o = (state == S_DONE);
        if (state == S_DONE) begin
          state_nxt = S_IDLE;
        end
        if (accept) begin
          if (cmd_len_i == '0) begin
            state_nxt = S_DONE;
          end else if (cmd_wr_i) begin
            state_nxt = S_WR;
          end else begin
            state_nxt = S_RD_ADDR;
          end
        end
      end
      S_WR: begin
        busy_o    = 1'b1;
        s_ready_o = 1'b1;
        if (wr_fire) begin
          ram_wr_en_o = 1'b1;
          ram_addr_o  = ptr;
          ram_wdata_o = s_data_i;
          if (last) begin
            state_nxt = S_DONE;
          end
        end
      end
      S_RD_ADDR: begin
        busy_o      = 1'b1;
        ram_rd_en_o = 1'b1;
        ram_addr_o  = ptr;
        state_nxt   = S_RD_CAP;
      end
      S_RD_CAP: begin
        busy_o      = 1'b1;
        ram_rd_en_o = 1'b1;
        ram_addr_o  = ptr;
        state_nxt   = S_RD_OUT;
      end
      S_RD_OUT: begin
        busy_o = 1'b1;
        if (rd_fire) begin
          state_nxt = last ? S_DONE : S_RD_ADDR;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Address pointer, remaining-word counter and read output register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr       <= '0;
      cnt       <= '0;
      m_data_o  <= '0;
      m_valid_o <= 1'b0;
    end else begin
      if (accept) begin
        ptr <= cmd_addr_i;
        cnt <= cmd_len_i;
      end
      if (wr_fire || rd_fire) begin
        ptr <= ptr + ADDR_BIT'(1);
        cnt <= cnt - LEN_W'(1);
      end
      if (state == S_RD_CAP) begin
        m_data_o  <= ram_rdata_i;
        m_valid_o <= 1'b1;
      end
      if (rd_fire) begin
        m_valid_o <= 1'b0;
      end
    end
  end

`ifdef RAM_BURST_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  // Running XOR of every word handed over in the current burst
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csum <= '0;
    end else if (accept) begin
      csum <= '0;
    end else if (wr_fire) begin
      csum <= csum ^ s_data_i;
    end else if (rd_fire) begin
      csum <= csum ^ m_data_o;
    end
  end

  assign checksum_o = csum;
`else
  assign checksum_o = DATA_W'(0);
`endif

endmodule

// File: tb/tb_ram_burst_master.sv
// Testbench for ram_burst_master: behavioural RAM, reference memory image,
// table of directed bursts, randomized bursts and hand-written corner cases.
module tb_ram_burst_master;

  localparam int unsigned AW    = 8;
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int          BUDGET = 5000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_start = 1'b0;
  logic          cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          busy;
  logic          done;
  logic [31:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          ram_wr_en;
  logic          ram_rd_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = '0;
  logic [31:0]   checksum;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ram     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  typedef struct {
    bit wr;
    int addr;
    int len;
    int vpct;
    int rpct;
    bit fixed;
    bit noise;
    int exp_cycles;
  } vec_t;

  vec_t vecs [11];

  ram_burst_master #(.ADDR_BIT(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_start_i (cmd_start),
    .cmd_wr_i    (cmd_wr),
    .cmd_addr_i  (cmd_addr),
    .cmd_len_i   (cmd_len),
    .busy_o      (busy),
    .done_o      (done),
    .s_data_i    (s_data),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .m_data_o    (m_data),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .ram_wr_en_o (ram_wr_en),
    .ram_rd_en_o (ram_rd_en),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .checksum_o  (checksum)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read; data is garbage unless rd_en was high
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_addr] <= ram_wdata;
    if (ram_rd_en) ram_rdata <= ram[ram_addr];
    else           ram_rdata <= 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_ck(input logic [31:0] sum);
`ifdef RAM_BURST_CHECKSUM_EN
    return sum;
`else
    return 32'h0 & sum;
`endif
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},   32'(busy),      32'd0);
    check({tag, "_done"},   32'(done),      32'd0);
    check({tag, "_sready"}, 32'(s_ready),   32'd0);
    check({tag, "_mvalid"}, 32'(m_valid),   32'd0);
    check({tag, "_wren"},   32'(ram_wr_en), 32'd0);
    check({tag, "_rden"},   32'(ram_rd_en), 32'd0);
    check({tag, "_addr"},   32'(ram_addr),  32'd0);
    check({tag, "_wdata"},  ram_wdata,      32'd0);
    check({tag, "_mdata"},  m_data,         32'd0);
    check({tag, "_csum"},   checksum,       32'd0);
  endtask

  // Entered and left at posedge+1; command is accepted at the next edge
  task automatic issue_cmd(input bit wr, input int addr, input int len);
    cmd_start = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = AW'(addr);
    cmd_len   = LW'(len);
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  // Runs one burst against the reference memory image and checks completion
  task automatic run_burst(input vec_t v);
    logic [31:0] sum;
    int i;
    int cyc;
    int a;
    sum = '0;
    i   = 0;
    cyc = 0;
    issue_cmd(v.wr, v.addr, v.len);
    while (i < v.len && cyc < BUDGET) begin
      cmd_start = v.noise && (cyc == 0);
      cmd_wr    = ~v.wr;
      cmd_addr  = AW'(8'h80);
      cmd_len   = LW'(5);
      s_valid   = v.wr && ($urandom_range(99) < v.vpct);
      s_data    = v.fixed ? 32'(32'h1111_1111 * (i + 1)) : $urandom;
      m_ready   = !v.wr && ($urandom_range(99) < v.rpct);
      a = (v.addr + i) % DEPTH;
      @(negedge clk);
      check("excl",  32'(ram_wr_en & ram_rd_en), 32'd0);
      check("busy",  32'(busy), 32'd1);
      if (v.wr) begin
        check("s_ready", 32'(s_ready), 32'd1);
        check("wr_en",   32'(ram_wr_en), 32'(s_valid));
        if (s_valid) begin
          check("wr_addr", 32'(ram_addr), 32'(a));
          check("wdata",   ram_wdata, s_data);
          ref_mem[a] = s_data;
          sum ^= s_data;
          i++;
        end
      end else begin
        check("s_ready_rd", 32'(s_ready), 32'd0);
        if (ram_rd_en) check("rd_addr", 32'(ram_addr), 32'(a));
        if (m_valid) begin
          check("rd_while_hold", 32'(ram_rd_en), 32'd0);
          if (m_ready) begin
            check("m_data", m_data, ref_mem[a]);
            sum ^= ref_mem[a];
            i++;
          end
        end
      end
      cyc++;
      @(posedge clk); #1;
      cmd_start = 1'b0;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    if (i < v.len) begin
      n_cmp++;
      n_bad++;
      $display("FAIL burst_timeout: actual=%0d words required=%0d words", i, v.len);
    end
    if (v.exp_cycles >= 0) check("cycles", 32'(cyc), 32'(v.exp_cycles));
    @(negedge clk);
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy",  32'(busy), 32'd0);
    check("done_wren",  32'(ram_wr_en), 32'd0);
    check("done_rden",  32'(ram_rd_en), 32'd0);
    check("done_csum",  checksum, exp_ck(sum));
    @(posedge clk); #1;
    @(negedge clk);
    check("done_once",  32'(done), 32'd0);
    check("idle_busy",  32'(busy), 32'd0);
    check("idle_csum",  checksum, exp_ck(sum));
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t rv;
    int   cyc;
    logic [31:0] w;

    for (int k = 0; k < int'(DEPTH); k++) begin
      w = $urandom;
      ram[k]     = w;
      ref_mem[k] = w;
    end

    //          wr addr   len  vpct rpct fix noise cycles
    vecs[0]  = '{1, 'h10,   4, 100, 100, 1, 0,   4};
    vecs[1]  = '{0, 'h10,   4, 100, 100, 0, 0,  12};
    vecs[2]  = '{1, 'hFE,   3, 100, 100, 0, 0,   3};
    vecs[3]  = '{0, 'hFE,   3, 100, 100, 0, 0,   9};
    vecs[4]  = '{1, 'h00,   0, 100, 100, 0, 0,   0};
    vecs[5]  = '{1, 'h20,   3, 100, 100, 0, 1,   3};
    vecs[6]  = '{0, 'h20,   3, 100, 100, 0, 1,   9};
    vecs[7]  = '{1, 'h40,   8,  50, 100, 0, 0,  -1};
    vecs[8]  = '{0, 'h40,   8, 100,  40, 0, 0,  -1};
    vecs[9]  = '{1, 'h00, 256, 100, 100, 0, 0, 256};
    vecs[10] = '{0, 'h00, 256, 100,  70, 0, 0,  -1};

    // Reset state
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table
    for (int k = 0; k < 11; k++) begin
      run_burst(vecs[k]);
      if (k == 0) check("csum_const", checksum, exp_ck(32'h4444_4444));
    end

    // Read backpressure: word held stable, no RAM read until handshake
    issue_cmd(1'b0, 'h10, 2);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!m_valid && cyc < 10);
    check("bp_latency", 32'(cyc), 32'd3);
    check("bp_data0",   m_data, ref_mem[8'h10]);
    repeat (5) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_hold_valid", 32'(m_valid), 32'd1);
      check("bp_hold_data",  m_data, ref_mem[8'h10]);
      check("bp_hold_rden",  32'(ram_rd_en), 32'd0);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", 32'(m_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_rd2_en",   32'(ram_rd_en), 32'd1);
    check("bp_rd2_addr", 32'(ram_addr), 32'h11);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_data1",  m_data, ref_mem[8'h11]);
    check("bp_valid1", 32'(m_valid), 32'd1);
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    check("bp_done", 32'(done), 32'd1);
    @(posedge clk); #1;

    // Asynchronous reset after two of four write words
    issue_cmd(1'b1, 'h30, 4);
    for (int j = 0; j < 2; j++) begin
      s_valid = 1'b1;
      s_data  = $urandom;
      ref_mem[8'h30 + j] = s_data;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = $urandom;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    rv = '{0, 'h30, 4, 100, 100, 0, 0, 12};
    run_burst(rv);

    // Randomized bursts against the reference memory
    for (int r = 0; r < 30; r++) begin
      rv.wr    = 1'($urandom_range(1));
      rv.addr  = int'($urandom_range(DEPTH - 1));
      rv.len   = int'($urandom_range(12));
      rv.vpct  = int'($urandom_range(100, 30));
      rv.rpct  = int'($urandom_range(100, 30));
      rv.fixed = 1'b0;
      rv.noise = 1'($urandom_range(1));
      rv.exp_cycles = -1;
      run_burst(rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
